// File: rtl/pwm_bank.sv
// pwm_bank: bank of NUM_CH PWM channels sharing one prescaler and one period
// counter, configured through a small byte-wide register file.
//
// Ports:
//   clk         system clock, all state updates on the rising edge
//   rst_n       asynchronous active-low reset
//   wr_en       register write strobe (one write per cycle)
//   wr_addr     register write address
//   wr_data     register write data
//   rd_addr     register read address
//   rd_data     registered read data, valid one cycle after rd_addr
//   pwm_out     per-channel PWM output (registered)
//   period_tick one-cycle pulse in the cycle the period counter wraps to 0
//
// Register map:
//   0x00        out_en[NUM_CH-1:0]
//   0x01        pwm_en[NUM_CH-1:0]
//   0x02        prescale[7:0]
//   0x10+i      duty[i][CNT_W-1:0], i < NUM_CH
module pwm_bank #(
    parameter int NUM_CH = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [6:0]        wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [6:0]        rd_addr,
    output logic [7:0]        rd_data,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              period_tick
);

    localparam logic [6:0]       ADDR_OUT_EN   = 7'h00;
    localparam logic [6:0]       ADDR_PWM_EN   = 7'h01;
    localparam logic [6:0]       ADDR_PRESCALE = 7'h02;
    localparam int unsigned      DUTY_BASE     = 16;
    localparam logic [CNT_W-1:0] CNT_MAX       = '1;

    // Architectural registers
    logic [NUM_CH-1:0] out_en;
    logic [NUM_CH-1:0] pwm_en;
    logic [7:0]        prescale;
    logic [CNT_W-1:0]  duty   [NUM_CH];

    // Timing state
    logic [7:0]        pcnt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  shadow [NUM_CH];

    // Next-state values
    logic [NUM_CH-1:0] out_en_n;
    logic [NUM_CH-1:0] pwm_en_n;
    logic [7:0]        prescale_n;
    logic [CNT_W-1:0]  duty_n   [NUM_CH];
    logic [7:0]        pcnt_n;
    logic [CNT_W-1:0]  cnt_n;
    logic [CNT_W-1:0]  shadow_n [NUM_CH];
    logic [NUM_CH-1:0] pwm_n;
    logic [7:0]        rd_n;
    logic              step;
    logic              wrap;

    // Register writes
    always_comb begin
        out_en_n   = out_en;
        pwm_en_n   = pwm_en;
        prescale_n = prescale;
        duty_n     = duty;
        if (wr_en) begin
            if (wr_addr == ADDR_OUT_EN)   out_en_n   = wr_data[NUM_CH-1:0];
            if (wr_addr == ADDR_PWM_EN)   pwm_en_n   = wr_data[NUM_CH-1:0];
            if (wr_addr == ADDR_PRESCALE) prescale_n = wr_data;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (wr_addr == 7'(DUTY_BASE + i)) duty_n[i] = wr_data[CNT_W-1:0];
            end
        end
    end

    // Prescaler, period counter and shadow load.
    // The >= compare makes a prescale lowered below the running count wrap
    // the prescaler on the very next cycle instead of running to 255.
    always_comb begin
        step     = (pcnt >= prescale);
        wrap     = step && (cnt == CNT_MAX);
        pcnt_n   = step ? 8'd0 : pcnt + 8'd1;
        cnt_n    = step ? cnt + 1'b1 : cnt;
        // Loads the pre-write duty, so a same-cycle write lands one period later
        shadow_n = shadow;
        if (wrap) shadow_n = duty;
    end

    // Output decode uses next-state values so enable writes show on pwm_out
    // right after the write edge, and the compare lines up with the counter
    // value held in the same cycle.
    always_comb begin
        pwm_n = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (out_en_n[i]) begin
                if (!pwm_en_n[i])
                    pwm_n[i] = 1'b1;
                else
                    pwm_n[i] = (shadow_n[i] == CNT_MAX) || (cnt_n < shadow_n[i]);
            end
        end
    end

    // Read mux on current (pre-write) register contents
    always_comb begin
        rd_n = '0;
        if (rd_addr == ADDR_OUT_EN)   rd_n[NUM_CH-1:0] = out_en;
        if (rd_addr == ADDR_PWM_EN)   rd_n[NUM_CH-1:0] = pwm_en;
        if (rd_addr == ADDR_PRESCALE) rd_n = prescale;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (rd_addr == 7'(DUTY_BASE + i)) rd_n[CNT_W-1:0] = duty[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_en      <= '0;
            pwm_en      <= '0;
            prescale    <= '0;
            pcnt        <= '0;
            cnt         <= '0;
            rd_data     <= '0;
            pwm_out     <= '0;
            period_tick <= 1'b0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                duty[i]   <= '0;
                shadow[i] <= '0;
            end
        end else begin
            out_en      <= out_en_n;
            pwm_en      <= pwm_en_n;
            prescale    <= prescale_n;
            pcnt        <= pcnt_n;
            cnt         <= cnt_n;
            rd_data     <= rd_n;
            pwm_out     <= pwm_n;
            period_tick <= wrap;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                duty[i]   <= duty_n[i];
                shadow[i] <= shadow_n[i];
            end
        end
    end

endmodule

// File: tb/tb_pwm_bank.sv
// tb_pwm_bank: directed checks of pwm_bank. Instance "dut" uses the default
// 8-channel configuration; instance "dut_b" uses 4 channels and shares all
// inputs, so it sees the same write stream.
module tb_pwm_bank;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;
    logic [6:0] rd_addr;
    logic [7:0] rd_data;
    logic [7:0] pwm_out;
    logic       period_tick;
    logic [7:0] rd_data_b;
    logic [3:0] pwm_out_b;
    logic       period_tick_b;

    int total  = 0;
    int passed = 0;
    int fails  = 0;
    int hc [8];

    pwm_bank #(.NUM_CH(8), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data),
        .pwm_out(pwm_out), .period_tick(period_tick)
    );

    pwm_bank #(.NUM_CH(4), .CNT_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data_b),
        .pwm_out(pwm_out_b), .period_tick(period_tick_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 2 time units
    // after the rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [6:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [6:0] a);
        rd_addr = a;
        step();
    endtask

    // Steps until period_tick is seen (at least one step), returns the count.
    task automatic wait_tick(input int bound, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!period_tick && n < bound);
    endtask

    // Called in a tick cycle; counts cycles and per-channel high cycles up to
    // the next tick. Optionally writes duty[2] at cycle wr_at.
    task automatic measure(input int wr_at, input logic [7:0] wr_val, output int cycles);
        cycles = 0;
        for (int i = 0; i < 8; i++) hc[i] = 0;
        do begin
            for (int i = 0; i < 8; i++) hc[i] += int'(pwm_out[i]);
            cycles++;
            if (cycles == wr_at) begin
                wr_en = 1'b1; wr_addr = 7'h12; wr_data = wr_val;
            end
            step();
            wr_en = 1'b0;
        end while (!period_tick && cycles < 5000);
    endtask

    initial begin
        int n;
        int cyc;

        wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("reset_pwm", pwm_out, 8'h00);
        chk("reset_rd", rd_data, 8'h00);
        chk("reset_tick", period_tick, 1'b0);
        step();
        step();
        rst_n = 1'b1;

        // Readback
        wr(7'h00, 8'hA5);
        chk("static_a5_pwm", pwm_out, 8'hA5);
        rd(7'h00);
        chk("rd_out_en", rd_data, 8'hA5);
        rd(7'h7F);
        chk("rd_unmapped_7f", rd_data, 8'h00);
        rd(7'h00);
        chk("rd_out_en_again", rd_data, 8'hA5);

        // Asynchronous reset mid-run
        rst_n = 1'b0;
        #1;
        chk("async_rst_pwm", pwm_out, 8'h00);
        chk("async_rst_rd", rd_data, 8'h00);
        step();
        step();
        rst_n = 1'b1;
        wait_tick(400, n);
        chk("first_tick_after_release", n, 256);

        // Static mode
        wr(7'h00, 8'h0F);
        chk("static_0f", pwm_out, 8'h0F);
        wr(7'h00, 8'h00);
        chk("static_off", pwm_out, 8'h00);

        // Duty ratio, prescale 0
        wr(7'h10, 8'h40);
        wr(7'h00, 8'h01);
        wr(7'h01, 8'h01);
        wait_tick(600, n);
        chk("tick_seen_duty", period_tick, 1'b1);
        measure(0, 8'h00, cyc);
        chk("period_256", cyc, 256);
        chk("ch0_high_64", hc[0], 64);

        // Extremes: ch1 duty 0, ch3 duty 0xFF, over three periods
        wr(7'h11, 8'h00);
        wr(7'h13, 8'hFF);
        wr(7'h00, 8'h0B);
        wr(7'h01, 8'h0B);
        wait_tick(600, n);
        for (int p = 0; p < 3; p++) begin
            measure(0, 8'h00, cyc);
            chk("ext_period", cyc, 256);
            chk("ch1_const_low", hc[1], 0);
            chk("ch3_const_high", hc[3], 256);
        end

        // Prescale 3 and glitch-free duty update on ch2
        wr(7'h12, 8'h20);
        wr(7'h00, 8'h04);
        wr(7'h01, 8'h04);
        wr(7'h02, 8'h03);
        rd(7'h02);
        chk("rd_prescale", rd_data, 8'h03);
        wait_tick(2000, n);
        chk("tick_seen_ps3", period_tick, 1'b1);
        measure(0, 8'h00, cyc);
        chk("period_1024", cyc, 1024);
        chk("ch2_high_32_steps", hc[2], 128);
        measure(100, 8'hC0, cyc);
        chk("period_1024_upd", cyc, 1024);
        chk("ch2_old_duty_kept", hc[2], 128);
        rd(7'h12);
        chk("rd_duty_written", rd_data, 8'hC0);
        wait_tick(2000, n);
        measure(0, 8'h00, cyc);
        chk("period_1024_new", cyc, 1024);
        chk("ch2_high_192_steps", hc[2], 768);

        // Unmapped write on the 4-channel instance
        wr(7'h01, 8'h00);
        chk("static_ch2_a", pwm_out, 8'h04);
        chk("static_ch2_b", pwm_out_b, 4'h4);
        wr(7'h15, 8'hFF);
        chk("b_pwm_unchanged", pwm_out_b, 4'h4);
        rd(7'h15);
        chk("b_rd_15", rd_data_b, 8'h00);
        chk("a_rd_15_mapped", rd_data, 8'hFF);
        rd(7'h10);
        chk("b_rd_duty0", rd_data_b, 8'h40);
        rd(7'h11);
        chk("b_rd_duty1", rd_data_b, 8'h00);
        rd(7'h12);
        chk("b_rd_duty2", rd_data_b, 8'hC0);
        rd(7'h13);
        chk("b_rd_duty3", rd_data_b, 8'hFF);
        rd(7'h00);
        chk("b_rd_out_en", rd_data_b, 8'h04);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
